// File: rtl/pwl_pkg.sv
`default_nettype none
// ============================================================================
// pwl_pkg : shared FSM states, fixed-point unit and saturation bounds for the
//           piecewise-linear jerk-system core.
// Revision: 1.0
// ============================================================================
package pwl_pkg;

    typedef logic [0:0] pwl_state_t;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // 1.0 in a format with 'frac' fractional bits
    function automatic longint one_fx(input int frac);
        return longint'(1) <<< frac;
    endfunction

    function automatic longint sat_max(input int w);
        return (longint'(1) <<< (w - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwl_sat_add.sv
`default_nettype none
// ============================================================================
// pwl_sat_add : signed a + b, saturated to the signed W-bit range.
//               Operand b may carry EXT extra headroom bits.
// Revision: 1.0
// ============================================================================
module pwl_sat_add
    import pwl_pkg::*;
#(
    parameter int W   = 22,
    parameter int EXT = 0
) (
    input  logic signed [W-1:0]     i_a,
    input  logic signed [W+EXT-1:0] i_b,
    output logic signed [W-1:0]     o_sum
);

    localparam int SW = W + EXT + 1;
    localparam logic signed [SW-1:0] c_max = SW'(sat_max(W));
    localparam logic signed [SW-1:0] c_min = SW'(sat_min(W));

    logic signed [SW-1:0] w_sum;

    always_comb begin
        w_sum = SW'(i_a) + SW'(i_b);
        if (w_sum > c_max) begin
            o_sum = c_max[W-1:0];
        end else if (w_sum < c_min) begin
            o_sum = c_min[W-1:0];
        end else begin
            o_sum = w_sum[W-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/pwl_chaos_core.sv
`default_nettype none
// ============================================================================
// pwl_chaos_core : Euler integrator of the jerk system x'=y, y'=z,
//                  z'=sgn(x)-x-y-a*z with decimated, back-pressured output.
// Revision: 1.0
// ============================================================================
module pwl_chaos_core
    import pwl_pkg::*;
#(
    parameter int WIDTH   = 22,
    parameter int FRAC    = 18,
    parameter int H_SHIFT = 6,
    parameter int A_SHIFT = 1,
    parameter int DECIM   = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load_enable,
    input  logic                    i_run,
    input  logic signed [WIDTH-1:0] i_x0,
    input  logic signed [WIDTH-1:0] i_y0,
    input  logic signed [WIDTH-1:0] i_z0,
    output logic                    o_valid,
    input  logic                    o_ready,
    output logic signed [WIDTH-1:0] o_x,
    output logic signed [WIDTH-1:0] o_y,
    output logic signed [WIDTH-1:0] o_z
);

    localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int DW = WIDTH + 2;
    localparam logic [CW-1:0]           c_cnt_last = CW'(DECIM - 1);
    localparam logic signed [DW-1:0]    c_one      = DW'(one_fx(FRAC));
    localparam logic signed [WIDTH-1:0] c_half     = WIDTH'(one_fx(FRAC - 1));

    pwl_state_t              state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic signed [WIDTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
    logic signed [WIDTH-1:0] out_x_q, out_x_d, out_y_q, out_y_d, out_z_q, out_z_d;
    logic                    valid_q, valid_d;

    logic signed [WIDTH-1:0] w_y_inc, w_z_inc;
    logic signed [DW-1:0]    w_dz, w_dz_inc;
    logic signed [WIDTH-1:0] w_x_next, w_y_next, w_z_next;
    logic                    w_stall, w_step, w_wrap;

    // dz needs two guard bits: sgn(x) - x - y - a*z can reach ~3x full scale
    assign w_y_inc  = y_q >>> H_SHIFT;
    assign w_z_inc  = z_q >>> H_SHIFT;
    assign w_dz     = (x_q[WIDTH-1] ? -c_one : c_one) - DW'(x_q) - DW'(y_q)
                      - DW'(z_q >>> A_SHIFT);
    assign w_dz_inc = w_dz >>> H_SHIFT;

    pwl_sat_add #(.W(WIDTH), .EXT(0)) u_add_x (.i_a(x_q), .i_b(w_y_inc),  .o_sum(w_x_next));
    pwl_sat_add #(.W(WIDTH), .EXT(0)) u_add_y (.i_a(y_q), .i_b(w_z_inc),  .o_sum(w_y_next));
    pwl_sat_add #(.W(WIDTH), .EXT(2)) u_add_z (.i_a(z_q), .i_b(w_dz_inc), .o_sum(w_z_next));

    assign w_stall = valid_q && !o_ready;
    assign w_step  = (state_q == ST_RUN) && i_run && !w_stall;
    assign w_wrap  = (cnt_q == c_cnt_last);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        out_x_d = out_x_q;
        out_y_d = out_y_q;
        out_z_d = out_z_q;
        valid_d = valid_q;
        if (load_enable) begin
            x_d     = i_x0;
            y_d     = i_y0;
            z_d     = i_z0;
            cnt_d   = '0;
            valid_d = 1'b0;
            state_d = ST_IDLE;
        end else begin
            if (state_q == ST_IDLE) begin
                if (i_run) state_d = ST_RUN;
            end else begin
                if (!i_run) state_d = ST_IDLE;
            end
            if (valid_q && o_ready) valid_d = 1'b0;
            if (w_step) begin
                x_d   = w_x_next;
                y_d   = w_y_next;
                z_d   = w_z_next;
                cnt_d = w_wrap ? '0 : cnt_q + CW'(1);
                if (w_wrap) begin
                    out_x_d = w_x_next;
                    out_y_d = w_y_next;
                    out_z_d = w_z_next;
                    valid_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            x_q     <= c_half;
            y_q     <= '0;
            z_q     <= '0;
            out_x_q <= '0;
            out_y_q <= '0;
            out_z_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            out_x_q <= out_x_d;
            out_y_q <= out_y_d;
            out_z_q <= out_z_d;
            valid_q <= valid_d;
        end
    end

    assign o_valid = valid_q;
    assign o_x     = out_x_q;
    assign o_y     = out_y_q;
    assign o_z     = out_z_q;

endmodule
`default_nettype wire

// File: tb/tb_pwl_chaos_core.sv
`default_nettype none
// ============================================================================
// tb_pwl_chaos_core : self-checking bench, DECIM=1 and DECIM=4 instances
//                     against an arithmetic model of the jerk system.
// Revision: 1.0
// ============================================================================
module tb_pwl_chaos_core;

    localparam int     W    = 22;
    localparam int     FR   = 18;
    localparam int     HS   = 6;
    localparam int     AS   = 1;
    localparam longint ONE  = longint'(1) <<< FR;
    localparam longint MAXV = (longint'(1) <<< (W - 1)) - 1;
    localparam longint MINV = -(longint'(1) <<< (W - 1));

    logic clk = 1'b0;
    logic reset, load_enable, i_run, o_ready;
    logic signed [W-1:0] i_x0, i_y0, i_z0;
    logic                o_valid1, o_valid4;
    logic signed [W-1:0] x1, y1, z1, x4, y4, z4;

    int n_vec = 0;
    int n_err = 0;
    longint mx, my, mz;

    typedef struct {
        longint sx, sy, sz;
        int     idx;
        longint ex, ey, ez;
    } vec_t;
    vec_t tbl[8];

    always #5 clk = ~clk;

    pwl_chaos_core #(.WIDTH(W), .FRAC(FR), .H_SHIFT(HS), .A_SHIFT(AS), .DECIM(1)) dut1 (
        .clk(clk), .reset(reset), .load_enable(load_enable), .i_run(i_run),
        .i_x0(i_x0), .i_y0(i_y0), .i_z0(i_z0), .o_valid(o_valid1), .o_ready(o_ready),
        .o_x(x1), .o_y(y1), .o_z(z1));

    pwl_chaos_core #(.WIDTH(W), .FRAC(FR), .H_SHIFT(HS), .A_SHIFT(AS), .DECIM(4)) dut4 (
        .clk(clk), .reset(reset), .load_enable(load_enable), .i_run(i_run),
        .i_x0(i_x0), .i_y0(i_y0), .i_z0(i_z0), .o_valid(o_valid4), .o_ready(o_ready),
        .o_x(x4), .o_y(y4), .o_z(z4));

    task automatic chk(input string nm, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     nm, act, act, exp, exp, $time);
        end
    endtask

    function automatic longint sat(input longint v);
        if (v > MAXV) return MAXV;
        if (v < MINV) return MINV;
        return v;
    endfunction

    // one Euler step of the reference system on mx/my/mz
    task automatic model_step();
        longint g, dz, nx, ny, nz;
        g  = (mx >= 0) ? ONE : -ONE;
        dz = g - mx - my - (mz >>> AS);
        nx = sat(mx + (my >>> HS));
        ny = sat(my + (mz >>> HS));
        nz = sat(mz + (dz >>> HS));
        mx = nx; my = ny; mz = nz;
    endtask

    function automatic longint rnd_word(input int shr);
        logic signed [W-1:0] r;
        r = W'($urandom);
        return longint'(r) >>> shr;
    endfunction

    task automatic load(input longint sx, input longint sy, input longint sz);
        @(negedge clk);
        load_enable = 1'b1;
        i_x0 = W'(sx); i_y0 = W'(sy); i_z0 = W'(sz);
        @(negedge clk);
        chk("load_valid", longint'(o_valid1), 0);
        load_enable = 1'b0;
        mx = sx; my = sy; mz = sz;
    endtask

    // mode 0: ready always high (also checks DECIM=4 instance)
    // mode 1: random ready; mode 2: 10-cycle stall after the first sample
    task automatic run_stream(input int n, input int mode);
        int got = 0;
        int budget = 0;
        int stall_cnt = 0;
        bit shown = 1'b0;
        i_run = 1'b1;
        o_ready = 1'b1;
        while (got < n) begin
            @(negedge clk);
            budget++;
            if (budget > 600) begin
                chk("stream_timeout", got, n);
                return;
            end
            if (o_valid1) begin
                if (!shown) begin
                    model_step();
                    got++;
                    shown = 1'b1;
                    chk("smp_x", longint'(x1), mx);
                    chk("smp_y", longint'(y1), my);
                    chk("smp_z", longint'(z1), mz);
                    if (mode == 0) begin
                        chk("d4_valid", longint'(o_valid4), longint'(got % 4 == 0));
                        if (got % 4 == 0) begin
                            chk("d4_x", longint'(x4), mx);
                            chk("d4_y", longint'(y4), my);
                            chk("d4_z", longint'(z4), mz);
                        end
                    end
                end else begin
                    chk("hold_x", longint'(x1), mx);
                    chk("hold_y", longint'(y1), my);
                    chk("hold_z", longint'(z1), mz);
                end
            end else if (mode == 0 && got > 0) begin
                chk("steady_valid", longint'(o_valid1), 1);
            end
            case (mode)
                1:       o_ready = 1'($urandom_range(0, 1));
                2: begin
                    o_ready = !(got == 1 && stall_cnt < 10);
                    if (!o_ready) stall_cnt++;
                end
                default: o_ready = 1'b1;
            endcase
            if (o_valid1 && o_ready) shown = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; load_enable = 1'b0; i_run = 1'b0; o_ready = 1'b1;
        i_x0 = '0; i_y0 = '0; i_z0 = '0;

        // hand-derived vectors, then random seeds with model-derived results
        tbl[0] = '{0, 0, 0, 1, 0, 0, 'h01000};
        tbl[1] = '{0, 0, 0, 2, 0, 'h00040, 'h01FE0};
        tbl[2] = '{'h1FFFFF, 'h1FFFFF, 0, 1, 'h1FFFFF, 'h1FFFFF, -61440};
        tbl[3] = '{-262144, 0, 0, 1, -262144, 0, 0};
        tbl[4] = '{-2097152, -2097152, 0, 1, -2097152, -2097152, 61440};
        for (int i = 5; i < 8; i++) begin
            tbl[i].sx = rnd_word(2); tbl[i].sy = rnd_word(3); tbl[i].sz = rnd_word(1);
            tbl[i].idx = i - 2;
            mx = tbl[i].sx; my = tbl[i].sy; mz = tbl[i].sz;
            for (int k = 0; k < tbl[i].idx; k++) model_step();
            tbl[i].ex = mx; tbl[i].ey = my; tbl[i].ez = mz;
        end

        @(negedge clk);
        chk("rst_valid", longint'(o_valid1), 0);
        chk("rst_x", longint'(x1), 0);
        chk("rst_z", longint'(z1), 0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            i_run = 1'b0;
            o_ready = 1'b1;
            load(tbl[i].sx, tbl[i].sy, tbl[i].sz);
            i_run = 1'b1;
            for (int t = 0; t < 10 && !o_valid1; t++) @(negedge clk);
            chk("vec_valid", longint'(o_valid1), 1);
            repeat (tbl[i].idx - 1) @(negedge clk);
            chk("vec_x", longint'(x1), tbl[i].ex);
            chk("vec_y", longint'(y1), tbl[i].ey);
            chk("vec_z", longint'(z1), tbl[i].ez);
        end

        // steady stream with DECIM=4 cross-check
        i_run = 1'b0;
        load(0, 0, 0);
        run_stream(12, 0);

        // frozen output and state during a 10-cycle stall
        i_run = 1'b0;
        load(rnd_word(2), rnd_word(2), rnd_word(2));
        run_stream(6, 2);

        // random back-pressure, random seeds
        for (int s = 0; s < 4; s++) begin
            i_run = 1'b0;
            load(rnd_word(s), rnd_word(s), rnd_word(s));
            run_stream(25, 1);
        end

        // seed load while stalled with run still requested
        i_run = 1'b0;
        load(0, 0, 0);
        i_run = 1'b1;
        o_ready = 1'b0;
        for (int t = 0; t < 10 && !o_valid1; t++) @(negedge clk);
        model_step();
        chk("stall_smp_z", longint'(z1), mz);
        repeat (3) @(negedge clk);
        chk("stall_hold_z", longint'(z1), mz);
        load('h10000, -'h8000, 'h4000);
        run_stream(5, 0);

        // asynchronous reset between edges in the middle of a run
        i_run = 1'b0;
        load(rnd_word(2), rnd_word(2), rnd_word(2));
        run_stream(5, 0);
        #2 reset = 1'b1;
        #1;
        chk("arst_valid", longint'(o_valid1), 0);
        chk("arst_x", longint'(x1), 0);
        chk("arst_y", longint'(y1), 0);
        chk("arst_z", longint'(z1), 0);
        chk("arst_valid4", longint'(o_valid4), 0);
        @(negedge clk);
        reset = 1'b0;
        mx = ONE >>> 1; my = 0; mz = 0;
        run_stream(4, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pwl_chaos_core.md
PWL_CHAOS_CORE -- requirements
Module: pwl_chaos_core

Interface
REQ-001 Parameter WIDTH, default 22: state and output word width, two's complement.
REQ-002 Parameter FRAC, default 18: fractional bits; 1.0 = 2^FRAC.
REQ-003 Parameter H_SHIFT, default 6: Euler step h = 2^-H_SHIFT.
REQ-004 Parameter A_SHIFT, default 1: damping a = 2^-A_SHIFT.
REQ-005 Parameter DECIM, default 1 (legal >= 1): integration steps per emitted sample.
REQ-006 clk  in  1  single clock; all state changes on the rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 load_enable  in  1  load seed: while high, the state takes i_x0/i_y0/i_z0.
REQ-009 i_run  in  1  1 = integrate; 0 = pause in IDLE.
REQ-010 i_x0, i_y0, i_z0  in  WIDTH each  seed values.
REQ-011 o_valid  out  1  sample available.
REQ-012 o_ready  in  1  consumer accepts the sample when o_valid && o_ready.
REQ-013 o_x, o_y, o_z  out  WIDTH each  registered sample.

Function
REQ-014 The system SHALL be the jerk system x'=y, y'=z, z'=g(x)-x-y-a*z, with g(x)=+1.0 if x>=0, else -1.0.
REQ-015 One step SHALL compute from the old values x+=y>>>H_SHIFT, y+=z>>>H_SHIFT, z+=dz>>>H_SHIFT.
REQ-016 Step arithmetic SHALL use arithmetic shifts only, with no multipliers.
REQ-017 dz SHALL be formed at WIDTH+2 bits; each sum SHALL saturate to the signed WIDTH range.
REQ-018 The FSM SHALL have states IDLE and RUN.
REQ-019 The FSM SHALL go IDLE->RUN when i_run=1 and load_enable=0, and RUN->IDLE when i_run=0.
REQ-020 In RUN, one step SHALL occur per cycle unless stalled (o_valid && !o_ready).
REQ-021 While stalled, state, counter and outputs SHALL hold.
REQ-022 A decimation counter SHALL count steps 0..DECIM-1.
REQ-023 On the step that wraps the counter to 0, the new state SHALL be registered into o_x/o_y/o_z and o_valid SHALL be 1 from the next cycle.
REQ-024 With DECIM=1, o_valid SHALL rise one cycle after the first RUN step; in steady state it SHALL stay high at one sample per cycle while o_ready=1.
REQ-025 o_valid SHALL drop after a handshake unless a new sample is registered in the same cycle.
REQ-026 load_enable SHALL win over run and stall: state<=seed, counter<=0, o_valid<=0, FSM->IDLE.
REQ-027 Entering IDLE SHALL keep a pending o_valid sample until it is accepted.

Reset
REQ-028 Reset SHALL set x=2^(FRAC-1) (0.5), y=0, z=0, counter=0 and FSM=IDLE.
REQ-029 Reset SHALL set o_valid=0 and o_x=o_y=o_z=0, taking effect immediately and asynchronously, including mid-run.

Structure
REQ-030 A shared package pwl_pkg SHALL hold the FSM state typedef, the ONE(FRAC) constant and the saturation bound helpers.
REQ-031 A sub-module pwl_sat_add SHALL implement the parametrised saturating adder and be instantiated three times.

Verification
REQ-032 Test WIDTH=22, FRAC=18, H=6, A=1, DECIM=1; seed 0,0,0; run, o_ready=1 -> sample 1 = (0, 0, 0x01000); sample 2 = (0, 0x00040, 0x01FE0).
REQ-033 Test seed x=y=0x1FFFFF; one step -> o_x=0x1FFFFF (saturated, no wrap).
REQ-034 Test DECIM=4, o_ready=1 -> o_valid pulses one cycle in every 4; sample equals the 4th step of a DECIM=1 run.
REQ-035 Test o_ready=0 for 10 cycles after the first sample -> outputs and state frozen; release -> sequence continues identical to the unstalled reference.
REQ-036 Test load_enable during a stall -> o_valid=0 the next cycle and state=seed; after i_run, the first sample matches the seed run.
REQ-037 Test reset asserted between clock edges mid-run -> outputs 0 and o_valid=0 immediately; state returns to 0.5, 0, 0.
